hash_feed: RTL and testbench
============================

Name: hash_feed

Overview:
- Upstream stage of the SHA-512/384/HMAC hash core.
- Packs a byte stream (from the SPI receive path) into 1024-bit big-endian message blocks.
- Sequences the core per block through an en/rdy/done handshake and supplies block flags and the cumulative byte count used for padding.
- Sits between the SPI byte receiver and the hash top; drives its msg, msg_size, hash_op, hash_en and hash_clr inputs.

Parameters:
- BLK_BYTES, 128, bytes per message block; fixed by the SHA-512 block size and not to be changed.
- CNT_W, 32, width of the cumulative byte counter and of msg_size.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_mode  in  2  hash mode, copied into hash_op[3:2]; latched when a message's first byte is accepted
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_last  in  1  final byte of the message; qualified by in_valid & in_ready
- in_ready  out  1  byte accepted when in_valid & in_ready
- hash_rdy  in  1  core can accept a block
- hash_done  in  1  one-cycle pulse: core finished the current block
- hash_en  out  1  one-cycle block start pulse
- hash_op  out  5  [0]=first block, [1]=final block, [3:2]=latched mode, [4]=0
- hash_clr  out  1  one-cycle core clear at message start
- msg  out  1024  block data; byte i at msg[1023-8i -: 8]
- msg_size  out  CNT_W  cumulative message bytes including the current block
- busy  out  1  state != IDLE
- msg_done  out  1  one-cycle pulse: final block completed
- size_ovf  out  1  sticky: byte counter saturated

Behaviour:
- All outputs are registered except in_ready and busy, which decode from the state register.
- Reset values: all outputs 0, state IDLE, internal byte index 0. Exception: in_ready = 1 because state is IDLE.
- Reset in any state, including WAIT, abandons the message. The bench must not issue a late hash_done after reset; if one arrives it is ignored.
- State IDLE: in_ready = 1.
  - On byte accept: clear msg to zero, write the byte at index 0, set msg_size = 1, latch cfg_mode, clear size_ovf, set first flag.
  - Pulse hash_clr the following cycle.
  - If in_last, go to ISSUE; else go to FILL with index 1.
- State FILL: in_ready = 1.
  - Each accepted byte is written at the current index; index and msg_size each increment by 1.
  - If the byte is the 128th of the block (index 127) or has in_last set, go to ISSUE. Record the final flag from in_last.
  - Unwritten bytes stay zero.
- State ISSUE: in_ready = 0.
  - When hash_rdy = 1, register hash_en = 1 for one cycle, hash_op = {1'b0, mode, final, first}, and go to WAIT.
  - hash_op and msg hold stable from hash_en until the next block starts filling.
- State WAIT: in_ready = 0. hash_done is ignored in the hash_en cycle; after that the first hash_done pulse completes the block.
  - If final: pulse msg_done and go to IDLE.
  - Otherwise: clear msg and the first flag, reset index to 0, go to FILL.
- hash_done in any state other than WAIT is ignored.
- Boundary, last byte at index 127: a single full block with final = 1. No extra block is issued; padding is the core's job via msg_size.
- Boundary, byte counter overflow: msg_size saturates at 2^CNT_W - 1 and size_ovf is set; block sequencing continues unchanged.
- Throughput: one byte per cycle in IDLE/FILL. Minimum 1 cycle from the last byte to ISSUE; hash_en follows in the same cycle hash_rdy is first seen high in ISSUE, registered.
- msg_size is a byte count. Conversion to bits is the core's job.

Test Plan:
- Three bytes 0x61, 0x62, 0x63 with in_last on the third, hash_rdy = 1, mode 2'b00 -> hash_clr one pulse; hash_en once with hash_op = 5'b00011; msg[1023:1000] = 0x616263 and the rest 0; msg_size = 3; msg_done one cycle after hash_done.
- 128 bytes 0x00..0x7F, last on 0x7F -> exactly one hash_en with hash_op = 5'b00011; msg[7:0] = 0x7F; msg_size = 128.
- 129 bytes, mode 2'b01 -> block 1: hash_op = 5'b00101, msg_size = 128. in_ready stays 0 until hash_done. Block 2: hash_op = 5'b00110, msg[1023:1016] = byte 128, rest 0, msg_size = 129.
- hash_rdy held low for 10 cycles in ISSUE -> no hash_en, in_ready = 0, msg stable; hash_en appears the cycle after hash_rdy rises.
- Assert rst in WAIT, then a hash_done pulse, then a new 1-byte message -> no msg_done for the old message; new message issues hash_op = 5'b00011 with msg_size = 1.
- Spurious hash_done in FILL -> ignored; block data and count unaffected.

Source files
------------

// File: rtl/hash_feed.sv
// -----------------------------------------------------------------------------
// hash_feed
//
// Upstream stage of the SHA-512/384/HMAC hash core. Packs an incoming byte
// stream into 1024-bit big-endian message blocks, sequences the core one block
// at a time over an en/rdy/done handshake, and supplies the per-block
// first/final flags plus the cumulative byte count the core uses for padding.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   cfg_mode   hash mode, latched when a message's first byte is accepted
//   in_data    stream byte
//   in_valid   in_data valid
//   in_last    final byte of the message (qualified by in_valid & in_ready)
//   in_ready   byte accepted when in_valid & in_ready
//   hash_rdy   core can accept a block
//   hash_done  one-cycle pulse: core finished the current block
//   hash_en    one-cycle block start pulse
//   hash_op    {1'b0, mode[1:0], final, first}
//   hash_clr   one-cycle core clear at message start
//   msg        block data, byte i at msg[1023-8i -: 8]
//   msg_size   cumulative message bytes including the current block
//   busy       block packer is not idle
//   msg_done   one-cycle pulse: final block completed
//   size_ovf   sticky: byte counter saturated
// -----------------------------------------------------------------------------
module hash_feed #(
    parameter int BLK_BYTES = 128,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cfg_mode,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   hash_rdy,
    input  logic                   hash_done,
    output logic                   hash_en,
    output logic [4:0]             hash_op,
    output logic                   hash_clr,
    output logic [8*BLK_BYTES-1:0] msg,
    output logic [CNT_W-1:0]       msg_size,
    output logic                   busy,
    output logic                   msg_done,
    output logic                   size_ovf
);

    localparam int IDX_W = $clog2(BLK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       mode_q;
    logic             first_q;
    logic             final_q;

    logic accept;
    logic blk_full;
    logic done_ok;
    logic size_max;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
    assign busy     = (state_q != S_IDLE);

    assign accept   = in_valid & in_ready;
    assign blk_full = (idx_q == LAST_IDX);
    // hash_en is still high in the first WAIT cycle; a done seen then belongs
    // to nothing this block started, so it is dropped.
    assign done_ok  = hash_done & ~hash_en;
    assign size_max = (msg_size == {CNT_W{1'b1}});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d; otherwise
        // a missed branch infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last ? S_ISSUE : S_FILL;
                end
            end
            S_FILL: begin
                if (accept && (in_last || blk_full)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hash_rdy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_ok) begin
                    state_d = final_q ? S_IDLE : S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Block buffer, counters, flags and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: msg is a wide register but it is a visible output that must
            // read as zero after reset, so it is reset like any control flop.
            msg      <= '0;
            msg_size <= '0;
            idx_q    <= '0;
            mode_q   <= '0;
            first_q  <= 1'b0;
            final_q  <= 1'b0;
            hash_en  <= 1'b0;
            hash_op  <= '0;
            hash_clr <= 1'b0;
            msg_done <= 1'b0;
            size_ovf <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples
            // pre-edge values regardless of statement order.
            hash_en  <= 1'b0;
            hash_clr <= 1'b0;
            msg_done <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        msg      <= {in_data, {(8*BLK_BYTES-8){1'b0}}};
                        idx_q    <= IDX_W'(1);
                        msg_size <= CNT_W'(1);
                        mode_q   <= cfg_mode;
                        size_ovf <= 1'b0;
                        first_q  <= 1'b1;
                        final_q  <= in_last;
                        hash_clr <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        msg[(BLK_BYTES-1-int'(idx_q))*8 +: 8] <= in_data;
                        idx_q   <= idx_q + IDX_W'(1);
                        final_q <= in_last;
                        // Saturate rather than wrap: a wrapped count would
                        // silently corrupt the core's length padding.
                        if (size_max) begin
                            size_ovf <= 1'b1;
                        end else begin
                            msg_size <= msg_size + CNT_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (hash_rdy) begin
                        hash_en <= 1'b1;
                        hash_op <= {1'b0, mode_q, final_q, first_q};
                    end
                end
                S_WAIT: begin
                    if (done_ok) begin
                        if (final_q) begin
                            msg_done <= 1'b1;
                        end else begin
                            // Next block starts from an all-zero buffer so a
                            // short tail leaves its unwritten bytes at zero.
                            msg     <= '0;
                            first_q <= 1'b0;
                            idx_q   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_feed.sv
`timescale 1ns/1ps
module tb_hash_feed;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          hash_rdy;
    logic          hash_done;

    logic          in_ready, hash_en, hash_clr, busy, msg_done, size_ovf;
    logic [4:0]    hash_op;
    logic [1023:0] msg;
    logic [31:0]   msg_size;

    // Narrow-counter twin: same stimulus, 8-bit byte counter to reach saturation.
    logic          in_ready_s, hash_en_s, hash_clr_s, busy_s, msg_done_s, size_ovf_s;
    logic [4:0]    hash_op_s;
    logic [1023:0] msg_s;
    logic [7:0]    msg_size_s;

    always #5 clk = ~clk;

    hash_feed #(.BLK_BYTES(128), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .hash_rdy(hash_rdy), .hash_done(hash_done), .hash_en(hash_en),
        .hash_op(hash_op), .hash_clr(hash_clr), .msg(msg), .msg_size(msg_size),
        .busy(busy), .msg_done(msg_done), .size_ovf(size_ovf)
    );

    hash_feed #(.BLK_BYTES(128), .CNT_W(8)) dut_small (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_s),
        .hash_rdy(hash_rdy), .hash_done(hash_done), .hash_en(hash_en_s),
        .hash_op(hash_op_s), .hash_clr(hash_clr_s), .msg(msg_s), .msg_size(msg_size_s),
        .busy(busy_s), .msg_done(msg_done_s), .size_ovf(size_ovf_s)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ctl_diff = 0;

    logic [7:0]    bytes_q[$];
    logic [1023:0] cap_msg[$];
    logic [31:0]   cap_size[$];
    logic [4:0]    cap_op[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_msg(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        bad = -1;
        for (int b = 127; b >= 0; b--) begin
            if (obs[1023-8*b -: 8] !== exp[1023-8*b -: 8]) bad = b;
        end
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: byte %0d observed %0h expected %0h", tag, bad,
                   obs[1023-8*bad -: 8], exp[1023-8*bad -: 8]);
        end
    endtask

    // Both instances must sequence identically; only the counter width differs.
    always @(negedge clk) begin
        if (!rst && (in_ready !== in_ready_s || hash_en !== hash_en_s ||
                     hash_op !== hash_op_s || hash_clr !== hash_clr_s ||
                     busy !== busy_s || msg_done !== msg_done_s || msg !== msg_s))
            ctl_diff++;
    end

    task automatic prep_rand(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic prep_seq(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'(i));
    endtask

    // Streams bytes_q as one message and plays the core: done arrives lat
    // cycles after hash_en. Options: glitch = extra done in the hash_en cycle,
    // hold = keep hash_rdy low for 10 ISSUE cycles, spur_at = done pulse while
    // filling, abort = reset while waiting for the first block.
    task automatic run_msg(input string name, input int n, input logic [1:0] mode, input int lat,
                           input bit glitch, input bit hold, input int spur_at, input bit abort);
        int sent, it, cd, issue_cnt, rise_it, real_done_it;
        int clr_cnt, done_cnt, rdy_bad, unstable, nblk, exp_size;
        bit pending, finished, spur_fired, saw_en;
        logic [1023:0] msg_hold, exp_msg;
        sent = 0; it = 0; cd = 0; issue_cnt = 0; rise_it = -1; real_done_it = -1;
        clr_cnt = 0; done_cnt = 0; rdy_bad = 0; unstable = 0;
        pending = 0; finished = 0; spur_fired = 0;
        msg_hold = '0;
        cap_msg.delete(); cap_size.delete(); cap_op.delete();
        cfg_mode = mode;
        if (hold) hash_rdy = 1'b0;

        while (!finished && it < 3000) begin
            @(negedge clk);
            it++;
            if (rst) begin
                rst = 1'b0;
                finished = 1;
                continue;
            end
            // observe
            saw_en = (hash_en === 1'b1);
            if (saw_en) begin
                cap_msg.push_back(msg);
                cap_size.push_back(msg_size);
                cap_op.push_back(hash_op);
                pending = 1;
                issue_cnt = 0;
                if (hold) check({name, " en_after_rdy"}, 64'(it), 64'(rise_it + 1));
            end
            if (hash_clr) clr_cnt++;
            if (msg_done) begin
                done_cnt++;
                finished = 1;
                check({name, " done_timing"}, 64'(it), 64'(real_done_it + 1));
            end
            if (pending && in_ready) rdy_bad++;
            if (sent == n && busy && in_ready) rdy_bad++;
            if (busy && !in_ready && !pending) begin
                if (issue_cnt == 0) msg_hold = msg;
                else if (msg !== msg_hold) unstable++;
                issue_cnt++;
            end
            // drive
            hash_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    hash_done = 1'b1;
                    pending = 0;
                    real_done_it = it;
                end
            end
            if (saw_en) begin
                cd = lat;
                if (glitch) hash_done = 1'b1;
                if (abort) rst = 1'b1;
            end
            if (spur_at > 0 && !spur_fired && sent == spur_at && in_ready && !pending) begin
                hash_done = 1'b1;
                spur_fired = 1;
            end
            if (hold && !hash_rdy && issue_cnt >= 10) begin
                hash_rdy = 1'b1;
                rise_it = it;
            end
            if (sent >= 1) cfg_mode = ~mode;
            if (in_ready && sent < n && !rst) begin
                in_valid = 1'b1;
                in_data  = bytes_q[sent];
                in_last  = (sent == n - 1);
                sent++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'h00;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; hash_done = 1'b0; hash_rdy = 1'b1;
        check({name, " finished"}, 64'(finished), 64'd1);

        if (!abort) begin
            nblk = (n + 127) / 128;
            check({name, " blocks"}, 64'(cap_op.size()), 64'(nblk));
            for (int k = 0; k < nblk && k < cap_op.size(); k++) begin
                exp_msg = '0;
                for (int b = 0; b < 128 && k * 128 + b < n; b++)
                    exp_msg[1023-8*b -: 8] = bytes_q[k*128+b];
                exp_size = ((k + 1) * 128 < n) ? (k + 1) * 128 : n;
                check_msg($sformatf("%s blk%0d msg", name, k), cap_msg[k], exp_msg);
                check($sformatf("%s blk%0d size", name, k), 64'(cap_size[k]), 64'(exp_size));
                check($sformatf("%s blk%0d op", name, k), 64'(cap_op[k]),
                      64'({1'b0, mode, (k == nblk - 1), (k == 0)}));
            end
            check({name, " clr_pulses"}, 64'(clr_cnt), 64'd1);
            check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
            check({name, " ready_low"}, 64'(rdy_bad), 64'd0);
            check({name, " msg_stable"}, 64'(unstable), 64'd0);
        end
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        cfg_mode = 2'b00; hash_rdy = 1'b1; hash_done = 1'b0;
        repeat (3) @(negedge clk);

        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst hash_en", 64'(hash_en), 64'd0);
        check("rst hash_op", 64'(hash_op), 64'd0);
        check("rst hash_clr", 64'(hash_clr), 64'd0);
        check("rst msg_size", 64'(msg_size), 64'd0);
        check("rst msg_done", 64'(msg_done), 64'd0);
        check("rst size_ovf", 64'(size_ovf), 64'd0);
        check_msg("rst msg", msg, '0);
        rst = 1'b0;

        bytes_q.delete();
        bytes_q.push_back(8'h61); bytes_q.push_back(8'h62); bytes_q.push_back(8'h63);
        run_msg("abc", 3, 2'b00, 1, 0, 0, -1, 0);

        prep_seq(128);
        run_msg("full128", 128, 2'b00, 2, 0, 0, -1, 0);

        prep_rand(129);
        run_msg("two_blk", 129, 2'b01, 3, 1, 0, -1, 0);

        prep_rand(5);
        run_msg("rdy_hold", 5, 2'b10, 1, 0, 1, -1, 0);

        prep_rand(50);
        run_msg("spur_fill", 50, 2'b11, 2, 0, 0, 20, 0);

        prep_rand(2);
        run_msg("abort", 2, 2'b01, 2, 0, 0, -1, 1);
        @(negedge clk);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort busy", 64'(busy), 64'd0);
        check("abort hash_op", 64'(hash_op), 64'd0);
        check("abort msg_size", 64'(msg_size), 64'd0);
        hash_done = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            hash_done = 1'b0;
            if (msg_done) done_seen++;
        end
        check("abort late_done", 64'(done_seen), 64'd0);
        bytes_q.delete();
        bytes_q.push_back(8'hA5);
        run_msg("after_abort", 1, 2'b00, 1, 0, 0, -1, 0);

        prep_rand(300);
        run_msg("long300", 300, 2'b10, 1, 0, 0, -1, 0);
        check("sat msg_size", 64'(msg_size_s), 64'd255);
        check("sat size_ovf", 64'(size_ovf_s), 64'd1);
        check("wide size_ovf", 64'(size_ovf), 64'd0);

        bytes_q.delete();
        bytes_q.push_back(8'h3C);
        run_msg("ovf_clear", 1, 2'b00, 1, 0, 0, -1, 0);
        check("clr size_ovf", 64'(size_ovf_s), 64'd0);
        check("clr msg_size", 64'(msg_size_s), 64'd1);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 260);
            prep_rand(n);
            run_msg($sformatf("rand%0d", r), n, 2'($urandom_range(0, 3)),
                    $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, -1, 0);
        end

        check("twin divergence", 64'(ctl_diff), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
